// File: rtl/mat_store_arbiter.sv
// Round-robin owner arbiter for the single-port matrix RAM; muxes the owner's bus and routes read data back.
// Latency: grant 1 cycle after req is sampled in IDLE; rvalid 1 cycle after a granted read.
// Backpressure: non-owners stay pending on req; the hold watchdog forces release after MAX_HOLD grant cycles.
module mat_store_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 1024,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        rel,
    input  logic [N_REQ-1:0]        we_i,
    input  logic [N_REQ*ADDR_W-1:0] addr_i,
    input  logic [N_REQ*DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [N_REQ-1:0]        rvalid,
    output logic [ID_W-1:0]         owner_id,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              tmo_nxt;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              vol_exit;
    logic              hold_hit;
    logic              own;

    // Round-robin search starting just above the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign vol_exit = rel[owner] | ~req[owner];
    assign hold_hit = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        tmo_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_OWN;
                    owner_nxt = win_id;
                    ptr_nxt   = win_id;
                    hold_nxt  = '0;
                end
            end
            S_OWN: begin
                hold_nxt = hold_cnt + 1'b1;
                if (vol_exit || hold_hit) begin
                    state_nxt = S_DRAIN;
                    // A voluntary release in the watchdog cycle is not an error.
                    tmo_nxt   = hold_hit & ~vol_exit;
                end
            end
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner       <= '0;
            ptr         <= ID_W'(N_REQ - 1);
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            rvalid      <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            timeout_err <= tmo_nxt;
            rvalid      <= gnt & ~we_i;
        end
    end

    // Bus mux is combinational from the registered owner so writes land with gnt.
    assign own       = (state == S_OWN);
    assign gnt       = own ? (N_REQ'(1) << owner) : '0;
    assign mem_we    = own & we_i[owner];
    assign mem_addr  = own ? addr_i[int'(owner)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = own ? wdata_i[int'(owner)*DATA_W +: DATA_W] : '0;
    assign rdata_o   = mem_rdata;
    assign owner_id  = owner;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mat_store_arbiter.sv
// Directed bench for mat_store_arbiter with MAX_HOLD=8 and hand-computed expectations.
module tb_mat_store_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req, rel, we_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [DW-1:0] mem_rdata;
    logic [N-1:0]  gnt, rvalid;
    logic          mem_we, busy, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata_o;
    logic [1:0]    owner_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mat_store_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_rdata(mem_rdata),
        .gnt(gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rdata_o(rdata_o), .rvalid(rvalid), .owner_id(owner_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        req = '0; rel = '0; we_i = '0; addr_i = '0; wdata_i = '0; mem_rdata = '0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_owner", owner_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_rvalid", rvalid, 0);
        tick;
        rst_n = 1'b1;

        // single write burst from requester 0
        tick;
        req = 4'b0001; we_i = 4'b0001; addr_i[9:0] = 10'd5; wdata_i[7:0] = 8'hA3;
        #1;
        chk("t1_gnt_c0", gnt, 0);
        tick;
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 5);
        chk("t1_wdata", mem_wdata, 8'hA3);
        chk("t1_busy", busy, 1);
        rel = 4'b0001;
        tick;
        rel = '0; req = '0; we_i = '0;
        #1;
        chk("t1_drain_gnt", gnt, 0);
        chk("t1_drain_we", mem_we, 0);
        chk("t1_drain_addr", mem_addr, 0);
        chk("t1_drain_busy", busy, 1);
        chk("t1_drain_tmo", timeout_err, 0);
        tick;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_owner", owner_id, 0);

        // requester 2 reads in its only OWN cycle
        req = 4'b0100; addr_i[29:20] = 10'd7;
        tick;
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_addr", mem_addr, 7);
        chk("t3_we", mem_we, 0);
        chk("t3_rvalid0", rvalid, 0);
        chk("t3_owner", owner_id, 2);
        rel = 4'b0100;
        tick;
        rel = '0; req = '0; mem_rdata = 8'h5C;
        #1;
        chk("t3_rvalid", rvalid, 4'b0100);
        chk("t3_rdata", rdata_o, 8'h5C);
        chk("t3_drain_gnt", gnt, 0);
        tick;
        chk("t3_rvalid_off", rvalid, 0);

        // requester 1 never releases; watchdog fires after 8 grant cycles
        req = 4'b0010;
        tick;
        chk("t4_gnt_1", gnt, 4'b0010);
        req = 4'b1010;
        for (int i = 2; i <= 8; i++) begin
            tick;
            chk($sformatf("t4_gnt_%0d", i), gnt, 4'b0010);
            chk($sformatf("t4_tmo_%0d", i), timeout_err, 0);
        end
        tick;
        chk("t4_drop_gnt", gnt, 0);
        chk("t4_tmo_pulse", timeout_err, 1);
        tick;
        chk("t4_tmo_once", timeout_err, 0);
        chk("t4_idle_gnt", gnt, 0);
        tick;
        chk("t4_next_gnt", gnt, 4'b1000);
        chk("t4_next_owner", owner_id, 3);

        // owner 3: non-owner rel ignored, own rel coincides with watchdog cycle
        rel = 4'b0010;
        tick;
        rel = '0;
        #1;
        chk("t5_nonowner_rel", gnt, 4'b1000);
        for (int i = 3; i <= 7; i++) begin
            tick;
            chk($sformatf("t5_gnt_%0d", i), gnt, 4'b1000);
        end
        tick;
        chk("t5_gnt_8", gnt, 4'b1000);
        rel = 4'b1000; we_i = 4'b0010; addr_i[19:10] = 10'd9; wdata_i[15:8] = 8'h66;
        tick;
        rel = '0;
        #1;
        chk("t5_drain_gnt", gnt, 0);
        chk("t5_no_tmo", timeout_err, 0);
        tick;
        chk("t5_idle_gnt", gnt, 0);
        tick;
        chk("t6_gnt", gnt, 4'b0010);
        chk("t6_we", mem_we, 1);
        chk("t6_addr", mem_addr, 9);
        chk("t6_wdata", mem_wdata, 8'h66);

        // asynchronous reset in the middle of a write burst
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_busy", busy, 0);
        tick;
        tick;
        rst_n = 1'b1; req = 4'b1111; we_i = '0;

        // all requesters held, each releasing in its third grant cycle
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            tick;
            chk($sformatf("t2_b%0d_c1", k), gnt, exp_g);
            tick;
            chk($sformatf("t2_b%0d_c2", k), gnt, exp_g);
            tick;
            chk($sformatf("t2_b%0d_c3", k), gnt, exp_g);
            rel = exp_g;
            tick;
            rel = '0;
            if (k == 4) req = '0;
            #1;
            chk($sformatf("t2_b%0d_gap1", k), gnt, 0);
            tick;
            chk($sformatf("t2_b%0d_gap2", k), gnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
